// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings for the data-memory responder
// Size codes, FSM state type and wait-counter width.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data-memory request/response bundle
// master = CPU side, slave = memory responder side.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, we, size, unsigned_ld, address, write_data,
        input  read_data, ready, busy, err
    );

    modport slave (
        input  req, we, size, unsigned_ld, address, write_data,
        output read_data, ready, busy, err
    );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and loads
// Store mask/replication, load lane select with sign/zero extension, misalignment detect.
import dmem_pkg::*;

module dmem_lane_align (
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_wmask    = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rword;
        o_misalign = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_wmask    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                o_misalign = i_addr_lo[0];
            end
            // SZ_WORD and the reserved code 2'b11 both act as a word access
            default: begin
                o_misalign = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory responding to CPU load/store requests
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses report err and do nothing.
import dmem_pkg::*;

module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [AW+1:0]      r_addr;
    logic [31:0]        r_wdata;
    logic               r_ready;
    logic               r_busy;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_idle;
    logic               w_we;
    logic [1:0]         w_size;
    logic               w_uns;
    logic [AW+1:0]      w_addr;
    logic [31:0]        w_wdata_in;
    logic [AW-1:0]      w_idx;
    logic [31:0]        w_rword;
    logic [3:0]         w_wmask;
    logic [31:0]        w_wdata;
    logic [31:0]        w_load;
    logic               w_misalign;
    logic               w_trap;
    logic               w_enter_resp;
    logic               w_commit;

    // With zero wait states the store commits on the acceptance edge, so the
    // datapath looks at the live request in IDLE and the latched one otherwise.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_we       = w_idle ? bus.we              : r_we;
    assign w_size     = w_idle ? bus.size            : r_size;
    assign w_uns      = w_idle ? bus.unsigned_ld     : r_uns;
    assign w_addr     = w_idle ? bus.address[AW+1:0] : r_addr;
    assign w_wdata_in = w_idle ? bus.write_data      : r_wdata;
    assign w_idx      = w_addr[AW+1:2];
    assign w_rword    = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_size     (w_size),
        .i_unsigned (w_uns),
        .i_addr_lo  (w_addr[1:0]),
        .i_wdata    (w_wdata_in),
        .i_rword    (w_rword),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load),
        .o_misalign (w_misalign)
    );

    assign w_trap       = w_misalign & TRAP_EN;
    assign w_enter_resp = (w_idle && bus.req && (WAIT_CYCLES == 0)) ||
                          ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_commit     = w_enter_resp && w_we && !w_trap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_size  <= SZ_BYTE;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_size  <= bus.size;
                        r_uns   <= bus.unsigned_ld;
                        r_addr  <= bus.address[AW+1:0];
                        r_wdata <= bus.write_data;
                        r_busy  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_err   <= w_trap;
                    r_rdata <= (!r_we && !w_trap) ? w_load : 32'h0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.read_data = r_rdata;
    assign bus.ready     = r_ready;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words; power of two, 16..4096.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  CPU request strobe; sampled only while busy=0.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-008 unsigned_ld  input  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
REQ-009 address  input  32  byte address.
REQ-010 write_data  input  32  store data; byte/half taken from low bits.
REQ-011 read_data  output  32  load result; valid only while ready=1.
REQ-012 ready  output  1  one-cycle response pulse ending every accepted request.
REQ-013 busy  output  1  high from acceptance until the cycle after ready.
REQ-014 err  output  1  misalignment flag; valid only while ready=1.

Function
REQ-015 FSM states IDLE, WAIT, RESP; acceptance = req=1 in IDLE at a rising edge; address, we, size, unsigned_ld, write_data latched at acceptance.
REQ-016 IDLE->WAIT on acceptance when WAIT_CYCLES>0, IDLE->RESP when WAIT_CYCLES=0; WAIT->RESP after exactly WAIT_CYCLES cycles in WAIT (4-bit down-counter); RESP->IDLE unconditionally.
REQ-017 Latency: request accepted at edge N -> ready=1 for exactly the cycle after edge N+WAIT_CYCLES+1; never asserted for more than one cycle.
REQ-018 busy=1 in WAIT and RESP; req while busy=1 ignored, not queued; back-to-back: new req sampled in IDLE the cycle after RESP.
REQ-019 Word index = address[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo DEPTH_WORDS*4 bytes).
REQ-020 Store committed at the edge entering RESP; only addressed lanes written: byte lane address[1:0], half lanes address[1]*2..+1, word all four.
REQ-021 Load: byte/half selected from addressed lane(s), extended to 32 bits per unsigned_ld; word returned as stored; store responses return read_data=0.
REQ-022 A load to the word stored by the immediately preceding request returns the new data (no stale read).
REQ-023 read_data and err 0 whenever ready=0.

Reset
REQ-024 reset=0 forces immediately: state IDLE, wait counter 0, ready 0, busy 0, read_data 0, err 0, latched request cleared.
REQ-025 Reset during WAIT abandons the request; pending store never written; storage array contents not reset.
REQ-026 First acceptance possible at the first rising edge after reset deasserts.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: half with address[0]=1 or word with address[1:0]!=0 completes normally in timing, performs no write, returns read_data=0 and err=1 with ready.
REQ-028 DMEM_MISALIGN_TRAP_EN undefined: misaligned low address bits truncated (half uses address&~1, word address&~3), access performed, err tied 0.

Structure
REQ-029 Package dmem_pkg holds size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, counter width constant.
REQ-030 One combinational sub-module dmem_lane_align: store lane-mask/data replication and load lane select/extension; FSM and storage stay in dmem_responder.

Verification
REQ-031 WAIT_CYCLES=2: store word 0xDEADBEEF @0x10, then load word @0x10 -> ready exactly 3 cycles after each acceptance, read_data=0xDEADBEEF, err=0.
REQ-032 Store byte 0x80 @0x13, load byte signed @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-033 WAIT_CYCLES=0, DEPTH_WORDS=256: store 0x12345678 @0x400, load word @0x0 -> 0x12345678 (wrap), ready one cycle after acceptance.
REQ-034 req held high continuously across 3 requests -> only IDLE-state samples accepted, one ready pulse each, busy low exactly one cycle between responses.
REQ-035 reset pulsed low during WAIT of store 0xAAAAAAAA @0x20 -> ready never asserts, outputs 0 at once; later load @0x20 returns prior contents.
REQ-036 Half store @0x21: with DMEM_MISALIGN_TRAP_EN -> err=1, read_data=0, memory unchanged; without -> err=0, data written at 0x20.
